// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_PULSE = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_PULSE = 3'd5,
    D_HOLD  = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 2;

  // {CS, AD, RD, WR} with every strobe deasserted
  localparam logic [3:0] CTRL_IDLE = 4'b1111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Phase down-counter: loads a value, counts to zero and stops there.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (count != {W{1'b0}}) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == {W{1'b0}});

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences one address phase and one data phase on a multiplexed RTC bus.
// All pad-facing controls are registered from the next state.
module rtc_bus_sequencer
  import rtc_bus_sequencer_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rnw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       CS,
  output logic       AD,
  output logic       RD,
  output logic       WR
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

  state_t        state, next_state;
  logic          rnw_q;
  logic [7:0]    addr_q, wdata_q;
  logic          load, tc;
  logic [CW-1:0] load_val;
  logic [3:0]    ctrl_q, n_ctrl;
  logic          n_oe, n_busy, n_done, n_rnw, a_ph, d_ph;
  logic [7:0]    n_bus, n_addr, n_wdata;

  // Counter reload value is one less than the phase length in cycles
  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      A_SETUP, D_SETUP: return CW'(SETUP_CYC - 1);
      A_PULSE, D_PULSE: return CW'(PULSE_CYC - 1);
      A_HOLD,  D_HOLD:  return CW'(HOLD_CYC - 1);
      default:          return {CW{1'b0}};
    endcase
  endfunction

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = A_SETUP;
      A_SETUP: if (tc)  next_state = A_PULSE;
      A_PULSE: if (tc)  next_state = A_HOLD;
      A_HOLD:  if (tc)  next_state = D_SETUP;
      D_SETUP: if (tc)  next_state = D_PULSE;
      D_PULSE: if (tc)  next_state = D_HOLD;
      D_HOLD:  if (tc)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    load     = (next_state != state);
    load_val = phase_len(next_state);
  end

  // In IDLE the request fields are captured on this same edge, so use them directly
  always_comb begin
    n_rnw   = (state == IDLE) ? rnw   : rnw_q;
    n_addr  = (state == IDLE) ? addr  : addr_q;
    n_wdata = (state == IDLE) ? wdata : wdata_q;
    a_ph    = (next_state == A_SETUP) || (next_state == A_PULSE) || (next_state == A_HOLD);
    d_ph    = (next_state == D_SETUP) || (next_state == D_PULSE) || (next_state == D_HOLD);
    n_ctrl  = CTRL_IDLE;
    n_ctrl[3] = !(a_ph || d_ph);
    n_ctrl[2] = !a_ph;
    n_ctrl[1] = !((next_state == D_PULSE) && n_rnw);
    n_ctrl[0] = !((next_state == A_PULSE) || ((next_state == D_PULSE) && !n_rnw));
    n_oe    = a_ph || (d_ph && !n_rnw);
    n_busy  = (next_state != IDLE);
    n_done  = (next_state == DONE);
    n_bus   = bus_out;
    if (a_ph) begin
      n_bus = n_addr;
    end else if (d_ph && !n_rnw) begin
      n_bus = n_wdata;
    end else begin
      n_bus = bus_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_IDLE;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata   <= 8'h00;
    end else begin
      ctrl_q  <= n_ctrl;
      bus_oe  <= n_oe;
      bus_out <= n_bus;
      busy    <= n_busy;
      done    <= n_done;
      if ((state == IDLE) && req) begin
        rnw_q   <= rnw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      // Sample the pad on the edge that closes the read strobe
      if ((state == D_PULSE) && tc && rnw_q) begin
        rdata <= bus_in;
      end
    end
  end

  assign {CS, AD, RD, WR} = ctrl_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized and directed bench for rtc_bus_sequencer: two instances (default
// and 1/1/1 timing) checked each cycle against a transaction-timeline model.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset, req, rnw;
  logic [7:0] addr, wdata, bus_in;
  logic [1:0] busy_w, done_w, cs_w, ad_w, rd_w, wr_w, oe_w;
  logic [7:0] rdata_w [2];
  logic [7:0] bus_out_w [2];

  int total = 0;
  int bad   = 0;

  int sc [2] = '{2, 1};
  int pc [2] = '{4, 1};
  int hc [2] = '{2, 1};

  bit         m_act [2];
  int         m_t [2];
  bit         m_rnw [2];
  logic [7:0] m_addr [2], m_wdata [2], m_bus [2], m_rdata [2];

  int done_cnt;
  int run [2];
  int last_run [2];
  bit found;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut0 (
    .clk(clk), .reset(reset), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .bus_out(bus_out_w[0]),
    .bus_oe(oe_w[0]), .bus_in(bus_in), .CS(cs_w[0]), .AD(ad_w[0]), .RD(rd_w[0]), .WR(wr_w[0])
  );

  rtc_bus_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .bus_out(bus_out_w[1]),
    .bus_oe(oe_w[1]), .bus_in(bus_in), .CS(cs_w[1]), .AD(ad_w[1]), .RD(rd_w[1]), .WR(wr_w[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_bus[i] = 8'h00; m_rdata[i] = 8'h00;
      run[i] = 0;
    end
  endtask

  // Transaction is a timeline t = 0 .. 2L, with L = setup+pulse+hold
  task automatic model_step(input int i);
    int L;
    L = sc[i] + pc[i] + hc[i];
    if (m_act[i]) begin
      if (m_rnw[i] && (m_t[i] == L + sc[i] + pc[i] - 1)) m_rdata[i] = bus_in;
      m_t[i]++;
      if (m_t[i] == 2 * L + 1) m_act[i] = 1'b0;
    end else if (req) begin
      m_act[i] = 1'b1; m_t[i] = 0;
      m_rnw[i] = rnw; m_addr[i] = addr; m_wdata[i] = wdata;
    end
    if (m_act[i] && (m_t[i] < L)) m_bus[i] = m_addr[i];
    else if (m_act[i] && (m_t[i] < 2 * L) && !m_rnw[i]) m_bus[i] = m_wdata[i];
  endtask

  task automatic compare(input int i);
    int L, t;
    bit a, ia, id, rp, ap;
    L  = sc[i] + pc[i] + hc[i];
    a  = m_act[i];
    t  = m_t[i];
    ia = a && (t < L);
    id = a && (t >= L) && (t < 2 * L);
    ap = a && (t >= sc[i]) && (t < sc[i] + pc[i]);
    rp = a && (t >= L + sc[i]) && (t < L + sc[i] + pc[i]);
    check_val($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(a));
    check_val($sformatf("done%0d", i), 32'(done_w[i]), 32'(a && (t == 2 * L)));
    check_val($sformatf("cs%0d", i),   32'(cs_w[i]),   32'(!(ia || id)));
    check_val($sformatf("ad%0d", i),   32'(ad_w[i]),   32'(!ia));
    check_val($sformatf("wr%0d", i),   32'(wr_w[i]),   32'(!(ap || (rp && !m_rnw[i]))));
    check_val($sformatf("rd%0d", i),   32'(rd_w[i]),   32'(!(rp && m_rnw[i])));
    check_val($sformatf("oe%0d", i),   32'(oe_w[i]),   32'(ia || (id && !m_rnw[i])));
    check_val($sformatf("bus_out%0d", i), 32'(bus_out_w[i]), 32'(m_bus[i]));
    check_val($sformatf("rdata%0d", i),   32'(rdata_w[i]),   32'(m_rdata[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      compare(i);
      if (busy_w[i]) run[i]++;
      else begin
        if (run[i] != 0) last_run[i] = run[i];
        run[i] = 0;
      end
    end
    if (done_w[0]) done_cnt++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; rnw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
    reset = 1'b0;

    // write 0x45 to 0x21
    rnw = 1'b0; addr = 8'h21; wdata = 8'h45; req = 1'b1;
    cycle();
    req = 1'b0;
    repeat (24) cycle();
    check_val("wr_busy_len0", 32'(last_run[0]), 32'd17);
    check_val("wr_busy_len1", 32'(last_run[1]), 32'd7);

    // read 0x22 with pad at 0x59
    rnw = 1'b1; addr = 8'h22; bus_in = 8'h59; req = 1'b1;
    cycle();
    req = 1'b0;
    repeat (24) cycle();
    check_val("rd_rdata", 32'(rdata_w[0]), 32'h59);
    check_val("rd_busy_len1", 32'(last_run[1]), 32'd7);

    // second request while busy is dropped
    done_cnt = 0;
    rnw = 1'b0; addr = 8'h10; wdata = 8'h77; req = 1'b1;
    cycle();
    req = 1'b0;
    repeat (3) cycle();
    addr = 8'h33; req = 1'b1;
    cycle();
    req = 1'b0;
    repeat (20) cycle();
    check_val("reject_done_cnt", 32'(done_cnt), 32'd1);

    // held request: two transactions with one idle cycle between
    done_cnt = 0;
    rnw = 1'b0; addr = 8'h5a; wdata = 8'ha5; req = 1'b1;
    repeat (36) cycle();
    req = 1'b0;
    repeat (20) cycle();
    check_val("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // reset in the middle of a read strobe
    done_cnt = 0; found = 1'b0;
    rnw = 1'b1; addr = 8'h44; bus_in = 8'hc3; req = 1'b1;
    cycle();
    req = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (m_act[0] && (m_t[0] == 11)) begin
        found = 1'b1;
        break;
      end
    end
    check_val("find_dpulse", 32'(found), 32'd1);
    check_val("pre_rst_rd", 32'(rd_w[0]), 32'd0);
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) compare(i);
    repeat (2) cycle();
    check_val("rst_no_done", 32'(done_cnt), 32'd0);
    check_val("rst_rdata", 32'(rdata_w[0]), 32'd0);
    reset = 1'b0;
    rnw = 1'b0; addr = 8'h01; wdata = 8'h02; req = 1'b1;
    cycle();
    check_val("first_req_after_rst", 32'(busy_w[0]), 32'd1);
    req = 1'b0;
    repeat (20) cycle();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      req    = ($urandom_range(0, 3) == 0);
      rnw    = 1'($urandom);
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
      bus_in = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
